// File: rtl/block_rle_encoder.sv
// Run-length encoder for one zigzag-ordered 8x8 coefficient block. Emits a DC entry,
// then AC (run, value) entries with ZRL/EOB markers, all behind valid/ready handshakes.
//
// state | meaning
// IDLE  | waiting for a block; block_ready high
// DC    | DC tuple presented
// SCAN  | walking AC coefficients; out_valid_q marks a pending AC tuple at idx_q
// ZRL   | zero-run-length marker (16 zeros) presented
// EOB   | end-of-block marker presented
module block_rle_encoder #(
   parameter int BLOCK_SIZE = 64,
   parameter int COEF_W     = 12
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [BLOCK_SIZE-1:0][COEF_W-1:0]    block_in,
   input  logic                                 block_valid,
   output logic                                 block_ready,
   output logic [3:0]                           run,
   output logic signed [COEF_W-1:0]             vli_value,
   output logic                                 freq,
   output logic                                 last,
   output logic                                 out_valid,
   input  logic                                 out_ready
);

   localparam int IDX_W = $clog2(BLOCK_SIZE);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
   localparam logic [IDX_W-1:0] RUN_MAX  = IDX_W'(16);

   typedef enum logic [2:0] {IDLE, DC, SCAN, ZRL, EOB} state_t;

   state_t                            state_q, state_d;
   logic [BLOCK_SIZE-1:0][COEF_W-1:0] coef_q, coef_d;
   logic [IDX_W-1:0]                  last_nz_q, last_nz_d;
   logic [IDX_W-1:0]                  idx_q, idx_d;
   logic [IDX_W-1:0]                  zcnt_q, zcnt_d;
   logic [3:0]                        run_q, run_d;
   logic [COEF_W-1:0]                 vli_q, vli_d;
   logic                              freq_q, freq_d;
   logic                              last_q, last_d;
   logic                              out_valid_q, out_valid_d;

   logic [IDX_W-1:0] last_nz_in;
   logic [IDX_W-1:0] idx_nxt;
   logic [IDX_W-1:0] zrem;
   logic             xfer;

   always_comb begin
      last_nz_in = '0;
      for (int i = 1; i < BLOCK_SIZE; i++) begin
         if (block_in[i] != '0) last_nz_in = IDX_W'(i);
      end
   end

   assign idx_nxt = idx_q + IDX_W'(1);
   assign zrem    = zcnt_q - RUN_MAX;
   assign xfer    = out_valid_q && out_ready;

   always_comb begin
      state_d     = state_q;
      coef_d      = coef_q;
      last_nz_d   = last_nz_q;
      idx_d       = idx_q;
      zcnt_d      = zcnt_q;
      run_d       = run_q;
      vli_d       = vli_q;
      freq_d      = freq_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;

      case (state_q)
         IDLE: begin
            if (block_valid) begin
               coef_d      = block_in;
               last_nz_d   = last_nz_in;
               idx_d       = '0;
               zcnt_d      = '0;
               state_d     = DC;
               out_valid_d = 1'b1;
               run_d       = 4'd0;
               vli_d       = block_in[0];
               freq_d      = 1'b0;
               last_d      = 1'b0;
            end
         end
         DC: begin
            if (xfer) begin
               idx_d       = IDX_W'(1);
               zcnt_d      = '0;
               out_valid_d = 1'b0;
               if (last_nz_q == '0) begin
                  state_d     = EOB;
                  out_valid_d = 1'b1;
                  run_d       = 4'd0;
                  vli_d       = '0;
                  freq_d      = 1'b1;
                  last_d      = 1'b1;
               end else begin
                  state_d = SCAN;
                  // A nonzero first AC needs no scan cycle; present it straight away.
                  if (coef_q[1] != '0) begin
                     out_valid_d = 1'b1;
                     run_d       = 4'd0;
                     vli_d       = coef_q[1];
                     freq_d      = 1'b1;
                     last_d      = 1'b0;
                  end
               end
            end
         end
         SCAN: begin
            if (out_valid_q) begin
               if (out_ready) begin
                  zcnt_d      = '0;
                  out_valid_d = 1'b0;
                  if (idx_q == last_nz_q) begin
                     idx_d = idx_nxt;
                     if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                     end else begin
                        state_d     = EOB;
                        out_valid_d = 1'b1;
                        run_d       = 4'd0;
                        vli_d       = '0;
                        freq_d      = 1'b1;
                        last_d      = 1'b1;
                     end
                  end else begin
                     idx_d = idx_nxt;
                     if (coef_q[idx_nxt] != '0) begin
                        out_valid_d = 1'b1;
                        run_d       = 4'd0;
                        vli_d       = coef_q[idx_nxt];
                        freq_d      = 1'b1;
                        last_d      = (idx_nxt == LAST_IDX);
                     end
                  end
               end
            end else if (coef_q[idx_q] == '0) begin
               zcnt_d = zcnt_q + IDX_W'(1);
               idx_d  = idx_nxt;
            end else if (zcnt_q >= RUN_MAX) begin
               state_d     = ZRL;
               out_valid_d = 1'b1;
               run_d       = 4'd15;
               vli_d       = '0;
               freq_d      = 1'b1;
               last_d      = 1'b0;
            end else begin
               out_valid_d = 1'b1;
               run_d       = zcnt_q[3:0];
               vli_d       = coef_q[idx_q];
               freq_d      = 1'b1;
               last_d      = (idx_q == LAST_IDX);
            end
         end
         ZRL: begin
            // idx_q still points at the nonzero coefficient that ends this run.
            if (xfer) begin
               zcnt_d = zrem;
               if (zrem < RUN_MAX) begin
                  state_d     = SCAN;
                  out_valid_d = 1'b1;
                  run_d       = zrem[3:0];
                  vli_d       = coef_q[idx_q];
                  freq_d      = 1'b1;
                  last_d      = (idx_q == LAST_IDX);
               end
            end
         end
         EOB: begin
            if (xfer) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
            end
         end
         default: begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         coef_q      <= '0;
         last_nz_q   <= '0;
         idx_q       <= '0;
         zcnt_q      <= '0;
         run_q       <= '0;
         vli_q       <= '0;
         freq_q      <= 1'b0;
         last_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         coef_q      <= coef_d;
         last_nz_q   <= last_nz_d;
         idx_q       <= idx_d;
         zcnt_q      <= zcnt_d;
         run_q       <= run_d;
         vli_q       <= vli_d;
         freq_q      <= freq_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign block_ready = (state_q == IDLE) && !rst;
   assign run         = run_q;
   assign vli_value   = vli_q;
   assign freq        = freq_q;
   assign last        = last_q;
   assign out_valid   = out_valid_q;

endmodule
